// File: rtl/io_timer_pkg.sv
// Shared constants for the io_timer peripheral: register offsets, CTRL/STATUS
// bit positions and the default base address of the register block.
package io_timer_pkg;

  localparam logic [15:0] IO_TIMER_BASE_ADDR = 16'h1010;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CNT_L  = 3'd2;
  localparam logic [2:0] OFF_CNT_H  = 3'd3;
  localparam logic [2:0] OFF_CMP_L  = 3'd4;
  localparam logic [2:0] OFF_CMP_H  = 3'd5;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTOCLR  = 1;
  localparam int CTRL_IRQEN    = 2;
  localparam int CTRL_PSEL_LSB = 3;
  localparam int CTRL_PSEL_W   = 3;
  localparam int CTRL_W        = CTRL_PSEL_LSB + CTRL_PSEL_W;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_W     = 2;

endpackage

// File: rtl/timer_prescaler.sv
// 7-bit prescaler: emits a one-cycle tick every 2**psel enabled cycles and
// restarts from zero whenever cleared or disabled.
module timer_prescaler
  import io_timer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CTRL_PSEL_W-1:0] psel,
  output logic                   tick
);

  logic [6:0] r_pre;
  logic [6:0] w_limit;

  // Terminal count (1<<psel)-1 built as a mask so no bits are left unused.
  assign w_limit = ~(7'h7F << psel);
  assign tick    = en && (r_pre == w_limit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (clr || !en || tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 7'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer/compare responder with atomic 16-bit access
// through byte staging/shadow registers and a registered level interrupt.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = IO_TIMER_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dMemIOAddress,
  input  logic [7:0]  dMemIOIn,
  input  logic        dMemIOWriteEn,
  input  logic        dMemIOReadEn,
  output logic [7:0]  ioOut,
  output logic        irq
);

  logic              w_sel, w_wr, w_rd, w_tick;
  logic [2:0]        w_off;
  logic [CTRL_W-1:0] r_ctrl;
  logic [ST_W-1:0]   r_status, w_st_set, w_st_clr;
  logic [15:0]       r_cnt, r_cmp, w_cnt_next;
  logic [7:0]        r_cnt_stg, r_cmp_stg, r_cnt_shadow, r_io_out, w_rdata;
  logic              r_irq;

  assign w_sel = (dMemIOAddress[15:3] == BASE_ADDR[15:3]);
  assign w_off = dMemIOAddress[2:0];
  assign w_wr  = dMemIOWriteEn && w_sel;
  assign w_rd  = dMemIOReadEn && w_sel;

  timer_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_ctrl[CTRL_EN]),
    .clr   (w_wr && (w_off == OFF_CTRL)),
    .psel  (r_ctrl[CTRL_PSEL_LSB +: CTRL_PSEL_W]),
    .tick  (w_tick)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_cnt_next = r_cnt;
    w_st_set   = '0;
    if (w_tick) begin
      if (r_cnt == r_cmp) w_st_set[ST_MATCH] = 1'b1;
      if ((r_cnt == r_cmp) && r_ctrl[CTRL_AUTOCLR]) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next         = r_cnt + 16'd1;
        w_st_set[ST_OVF]   = (r_cnt == 16'hFFFF);
      end
    end
    // A CPU commit to CNT_H overrides the tick's increment.
    if (w_wr && (w_off == OFF_CNT_H)) w_cnt_next = {dMemIOIn, r_cnt_stg};
  end

  assign w_st_clr = (w_wr && (w_off == OFF_STATUS)) ? dMemIOIn[ST_W-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = {{(8-CTRL_W){1'b0}}, r_ctrl};
      OFF_STATUS: w_rdata = {{(8-ST_W){1'b0}}, r_status};
      OFF_CNT_L:  w_rdata = r_cnt[7:0];
      OFF_CNT_H:  w_rdata = r_cnt_shadow;
      OFF_CMP_L:  w_rdata = r_cmp[7:0];
      OFF_CMP_H:  w_rdata = r_cmp[15:8];
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= '0;
      r_status     <= '0;
      r_cnt        <= '0;
      r_cmp        <= 16'hFFFF;
      r_cnt_stg    <= '0;
      r_cmp_stg    <= '0;
      r_cnt_shadow <= '0;
      r_io_out     <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_status <= (r_status & ~w_st_clr) | w_st_set;
      r_io_out <= w_rd ? w_rdata : 8'h00;
      r_irq    <= r_ctrl[CTRL_IRQEN] & r_status[ST_MATCH];
      if (w_rd && (w_off == OFF_CNT_L)) r_cnt_shadow <= r_cnt[15:8];
      if (w_wr) begin
        case (w_off)
          OFF_CTRL:  r_ctrl    <= dMemIOIn[CTRL_W-1:0];
          OFF_CNT_L: r_cnt_stg <= dMemIOIn;
          OFF_CMP_L: r_cmp_stg <= dMemIOIn;
          OFF_CMP_H: r_cmp     <= {dMemIOIn, r_cmp_stg};
          default:   ;
        endcase
      end
    end
  end

  assign ioOut = r_io_out;
  assign irq   = r_irq;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios with hand-derived
// expectations plus randomized bus traffic against a cycle-level reference model.
module tb_io_timer;
  import io_timer_pkg::*;

  localparam logic [15:0] BASE = 16'h1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        we, re;
  logic [7:0]  io_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_timer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dMemIOAddress (addr),
    .dMemIOIn      (din),
    .dMemIOWriteEn (we),
    .dMemIOReadEn  (re),
    .ioOut         (io_out),
    .irq           (irq)
  );

  // Reference model state, expressed as the programmer-visible registers.
  logic [5:0]  m_ctrl;
  logic [1:0]  m_status;
  logic [15:0] m_cnt, m_cmp;
  logic [7:0]  m_cstg, m_pstg, m_shadow, m_out;
  logic        m_irq;
  int          m_phase;

  task automatic model_reset();
    m_ctrl = '0; m_status = '0; m_cnt = '0; m_cmp = 16'hFFFF;
    m_cstg = '0; m_pstg = '0; m_shadow = '0; m_out = '0; m_irq = 1'b0;
    m_phase = 0;
  endtask

  task automatic model_step(input logic w, input logic r,
                            input logic [15:0] a, input logic [7:0] d);
    logic hit, tick, match;
    logic [2:0]  off;
    logic [15:0] nc;
    logic [1:0]  set_f, clr_f;
    logic [7:0]  rv;
    int period;
    hit    = (a[15:3] == BASE[15:3]);
    off    = a[2:0];
    period = 1 << m_ctrl[5:3];
    tick   = m_ctrl[0] && (m_phase == period - 1);
    match  = (m_cnt == m_cmp);
    case (off)
      3'd0:    rv = {2'b00, m_ctrl};
      3'd1:    rv = {6'b0, m_status};
      3'd2:    rv = m_cnt[7:0];
      3'd3:    rv = m_shadow;
      3'd4:    rv = m_cmp[7:0];
      3'd5:    rv = m_cmp[15:8];
      default: rv = 8'h00;
    endcase
    m_out = (r && hit) ? rv : 8'h00;
    if (r && hit && off == 3'd2) m_shadow = m_cnt[15:8];
    m_irq = m_ctrl[2] & m_status[0];
    nc = m_cnt; set_f = '0; clr_f = '0;
    if (tick) begin
      if (match) set_f[0] = 1'b1;
      if (match && m_ctrl[1]) nc = 16'h0000;
      else begin
        nc = m_cnt + 16'd1;
        if (m_cnt == 16'hFFFF) set_f[1] = 1'b1;
      end
    end
    if (!m_ctrl[0] || tick || (w && hit && off == 3'd0)) m_phase = 0;
    else m_phase++;
    if (w && hit) begin
      case (off)
        3'd0:    m_ctrl = d[5:0];
        3'd1:    clr_f  = d[1:0];
        3'd2:    m_cstg = d;
        3'd3:    nc     = {d, m_cstg};
        3'd4:    m_pstg = d;
        3'd5:    m_cmp  = {d, m_pstg};
        default: ;
      endcase
    end
    m_cnt    = nc;
    m_status = (m_status & ~clr_f) | set_f;
  endtask

  task automatic cycle(input logic w, input logic r,
                       input logic [15:0] a, input logic [7:0] d);
    we = w; re = r; addr = a; din = d;
    @(posedge clk);
    model_step(w, r, a, d);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    cycle(1'b1, 1'b0, {BASE[15:3], off}, d);
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] v);
    cycle(1'b0, 1'b1, {BASE[15:3], off}, 8'h00);
    v = io_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  logic [7:0] reset_vals [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0;
    #12;
    n_tests++;
    if (irq !== 1'b0 || io_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs irq=%b ioOut=%h want 0/00", irq, io_out);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      n_tests++;
      if (v !== reset_vals[i]) begin
        n_fail++; $display("FAIL reset_read off=%0d got %h want %h", i, v, reset_vals[i]);
      end
    end
    rd(OFF_CMP_L, v);
    cycle(1'b0, 1'b1, 16'h1020, 8'h00);
    n_tests++;
    if (io_out !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_read got %h want 00", io_out);
    end
  endtask

  task automatic test_atomic();
    logic [7:0] v;
    wr(OFF_CNT_L, 8'h34);
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'h00) begin
      n_fail++; $display("FAIL cnt_staged_only got %h want 00", v);
    end
    wr(OFF_CNT_H, 8'h12);
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'h34) begin n_fail++; $display("FAIL cnt_commit_lo got %h want 34", v); end
    rd(OFF_CNT_H, v);
    n_tests++;
    if (v !== 8'h12) begin n_fail++; $display("FAIL cnt_commit_hi got %h want 12", v); end
    // Counter 0x12FE running every cycle crosses a byte boundary between reads.
    wr(OFF_CNT_L, 8'hFE);
    wr(OFF_CNT_H, 8'h12);
    wr(OFF_CTRL, 8'h01);
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'hFE) begin n_fail++; $display("FAIL shadow_lo got %h want FE", v); end
    idle(1);
    rd(OFF_CNT_H, v);
    n_tests++;
    if (v !== 8'h12) begin n_fail++; $display("FAIL shadow_hi got %h want 12", v); end
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL running_lo got %h want 01", v); end
    rd(OFF_CNT_H, v);
    n_tests++;
    if (v !== 8'h13) begin n_fail++; $display("FAIL running_hi got %h want 13", v); end
    wr(OFF_CTRL, 8'h00);
  endtask

  task automatic test_compare();
    logic [7:0] v;
    logic [7:0] exp_cnt [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    wr(OFF_CTRL, 8'h00);
    wr(OFF_CNT_L, 8'h00); wr(OFF_CNT_H, 8'h00);
    wr(OFF_CMP_L, 8'h05); wr(OFF_CMP_H, 8'h00);
    wr(OFF_STATUS, 8'h03);
    wr(OFF_CTRL, 8'h07);
    for (int j = 1; j <= 8; j++) begin
      rd(OFF_CNT_L, v);
      n_tests++;
      if (v !== exp_cnt[j-1] || irq !== (j >= 7)) begin
        n_fail++;
        $display("FAIL autoclr_seq step=%0d cnt=%h irq=%b want %h/%b",
                 j, v, irq, exp_cnt[j-1], (j >= 7));
      end
    end
    wr(OFF_CTRL, 8'h04);
    wr(OFF_STATUS, 8'h01);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_w1c_edge got %b want 1", irq); end
    idle(1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c got %b want 0", irq); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    wr(OFF_CTRL, 8'h00);
    wr(OFF_STATUS, 8'h03);
    wr(OFF_CNT_L, 8'hFE); wr(OFF_CNT_H, 8'hFF);
    wr(OFF_CTRL, 8'h11);
    idle(7);
    rd(OFF_STATUS, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_early got %h want 00", v); end
    rd(OFF_STATUS, v);
    n_tests++;
    if (v !== 8'h02) begin n_fail++; $display("FAIL ovf_set got %h want 02", v); end
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_wrap_lo got %h want 00", v); end
    rd(OFF_CNT_H, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_wrap_hi got %h want 00", v); end
    wr(OFF_CTRL, 8'h00);
  endtask

  task automatic test_collisions();
    logic [7:0] v;
    wr(OFF_CTRL, 8'h00);
    wr(OFF_CMP_L, 8'h03); wr(OFF_CMP_H, 8'h00);
    wr(OFF_CNT_L, 8'h00); wr(OFF_CNT_H, 8'h00);
    wr(OFF_STATUS, 8'h03);
    wr(OFF_CTRL, 8'h03);
    idle(3);
    wr(OFF_STATUS, 8'h01);
    rd(OFF_STATUS, v);
    n_tests++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL w1c_vs_set got %h want 01", v); end
    wr(OFF_CNT_L, 8'h00);
    wr(OFF_CNT_H, 8'h40);
    rd(OFF_CNT_L, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cnth_vs_tick_lo got %h want 00", v); end
    rd(OFF_CNT_H, v);
    n_tests++;
    if (v !== 8'h40) begin n_fail++; $display("FAIL cnth_vs_tick_hi got %h want 40", v); end
    wr(OFF_CTRL, 8'h00);
  endtask

  task automatic test_random();
    logic        w, r;
    logic [2:0]  off;
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 400; i++) begin
      w   = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 1) == 1;
      off = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {BASE[15:3], off};
      d   = 8'($urandom);
      if (a[2:0] == 3'd0) d[5:3] = 3'($urandom_range(0, 2));
      cycle(w, r, a, d);
      n_tests++;
      if (io_out !== m_out || irq !== m_irq) begin
        n_fail++;
        $display("FAIL random step=%0d ioOut=%h irq=%b want %h/%b", i, io_out, irq, m_out, m_irq);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    wr(OFF_CTRL, 8'h00);
    wr(OFF_STATUS, 8'h03);
    wr(OFF_CMP_L, 8'h02); wr(OFF_CMP_H, 8'h00);
    wr(OFF_CNT_L, 8'h00); wr(OFF_CNT_H, 8'h00);
    wr(OFF_CTRL, 8'h05);
    idle(5);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_before_reset got %b want 1", irq); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (irq !== 1'b0 || io_out !== 8'h00) begin
      n_fail++; $display("FAIL async_reset irq=%b ioOut=%h want 0/00", irq, io_out);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      n_tests++;
      if (v !== reset_vals[i]) begin
        n_fail++; $display("FAIL post_reset_read off=%0d got %h want %h", i, v, reset_vals[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_atomic();
    test_compare();
    test_overflow();
    test_collisions();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
